// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding,
// load-use hazard detection and branch flush.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   id_*                         decoded instruction fields from the decode stage
//   flush                        branch taken; the instruction entering EX becomes a bubble
//   exm_reg_write/rd/result      EX/MEM forwarding source
//   mwb_reg_write/rd/data        MEM/WB forwarding source
//   stall                        combinational; holds PC and IF/ID for one cycle
//   op1, op2, ex_store_data      forwarded ALU operands and store data
//   ALU_ctrl, ex_*               registered stage contents; control bits gated by ex_valid
//   stall_count                  saturating count of load-use stall cycles
module id_ex_stage #(
   parameter int unsigned Data_Width    = 32,
   parameter int unsigned Address_Width = 5,
   parameter int unsigned Cnt_Width     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [Address_Width-1:0] id_rs1,
   input  logic [Address_Width-1:0] id_rs2,
   input  logic [Address_Width-1:0] id_rd,
   input  logic [Data_Width-1:0]    id_rs1_data,
   input  logic [Data_Width-1:0]    id_rs2_data,
   input  logic [Data_Width-1:0]    id_imm,
   input  logic                     id_alusrc,
   input  logic                     id_uses_rs2,
   input  logic [3:0]               id_alu_ctrl,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_mem_write,
   input  logic                     flush,
   input  logic                     exm_reg_write,
   input  logic [Address_Width-1:0] exm_rd,
   input  logic [Data_Width-1:0]    exm_result,
   input  logic                     mwb_reg_write,
   input  logic [Address_Width-1:0] mwb_rd,
   input  logic [Data_Width-1:0]    mwb_data,
   output logic                     stall,
   output logic [Data_Width-1:0]    op1,
   output logic [Data_Width-1:0]    op2,
   output logic [3:0]               ALU_ctrl,
   output logic [Data_Width-1:0]    ex_store_data,
   output logic                     ex_valid,
   output logic [Address_Width-1:0] ex_rd,
   output logic                     ex_reg_write,
   output logic                     ex_mem_read,
   output logic                     ex_mem_write,
   output logic [Cnt_Width-1:0]     stall_count
);

   // Stored operand fields of the instruction currently in EX
   logic [Address_Width-1:0] ex_rs1_q, ex_rs2_q;
   logic [Data_Width-1:0]    ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
   logic                     ex_alusrc_q;

   logic                     hazard;
   logic [Data_Width-1:0]    fwd_rs1, fwd_rs2;

   // Load in EX whose destination is read by the instruction in decode.
   always_comb begin
      hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
               ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));
      stall  = hazard && !flush;
   end

   // EX/MEM wins over MEM/WB since it carries the younger result; x0 never forwards.
   always_comb begin
      fwd_rs1 = ex_rs1_data_q;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_rs1_q)) begin
         fwd_rs1 = exm_result;
      end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == ex_rs1_q)) begin
         fwd_rs1 = mwb_data;
      end

      fwd_rs2 = ex_rs2_data_q;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_rs2_q)) begin
         fwd_rs2 = exm_result;
      end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == ex_rs2_q)) begin
         fwd_rs2 = mwb_data;
      end
   end

   always_comb begin
      op1           = fwd_rs1;
      op2           = ex_alusrc_q ? ex_imm_q : fwd_rs2;
      ex_store_data = fwd_rs2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_rd         <= '0;
         ALU_ctrl      <= 4'b0000;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_alusrc_q   <= 1'b0;
         stall_count   <= '0;
      end else begin
         if (flush || stall) begin
            // Bubble: only the control bits matter, data fields keep their old values.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
         end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_valid && id_reg_write;
            ex_mem_read   <= id_valid && id_mem_read;
            ex_mem_write  <= id_valid && id_mem_write;
            ex_rd         <= id_rd;
            ALU_ctrl      <= id_alu_ctrl;
            ex_rs1_q      <= id_rs1;
            ex_rs2_q      <= id_rs2;
            ex_rs1_data_q <= id_rs1_data;
            ex_rs2_data_q <= id_rs2_data;
            ex_imm_q      <= id_imm;
            ex_alusrc_q   <= id_alusrc;
         end

         if (stall && (stall_count != {Cnt_Width{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// A second instance with a 4-bit stall counter shares all inputs so the
// saturation behaviour can be reached in a handful of cycles.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        id_alusrc, id_uses_rs2;
   logic [3:0]  id_alu_ctrl;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        flush;
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        mwb_reg_write;
   logic [4:0]  mwb_rd;
   logic [31:0] mwb_data;

   logic        stall;
   logic [31:0] op1, op2, ex_store_data;
   logic [3:0]  ALU_ctrl;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [4:0]  ex_rd;
   logic [15:0] stall_count;

   logic        s_stall;
   logic [31:0] s_op1, s_op2, s_ex_store_data;
   logic [3:0]  s_alu_ctrl;
   logic        s_ex_valid, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write;
   logic [4:0]  s_ex_rd;
   logic [3:0]  s_stall_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alusrc(id_alusrc), .id_uses_rs2(id_uses_rs2), .id_alu_ctrl(id_alu_ctrl),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
      .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
      .mwb_data(mwb_data), .stall(stall), .op1(op1), .op2(op2), .ALU_ctrl(ALU_ctrl),
      .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .stall_count(stall_count)
   );

   id_ex_stage #(.Cnt_Width(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alusrc(id_alusrc), .id_uses_rs2(id_uses_rs2), .id_alu_ctrl(id_alu_ctrl),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
      .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
      .mwb_data(mwb_data), .stall(s_stall), .op1(s_op1), .op2(s_op2), .ALU_ctrl(s_alu_ctrl),
      .ex_store_data(s_ex_store_data), .ex_valid(s_ex_valid), .ex_rd(s_ex_rd),
      .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
      .ex_mem_write(s_ex_mem_write), .stall_count(s_stall_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic alusrc, input logic uses_rs2,
                          input logic [3:0] ctrl, input logic rw, input logic mr,
                          input logic mw);
      id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
      id_rs1_data = d1;  id_rs2_data = d2;  id_imm = imm;
      id_alusrc = alusrc;  id_uses_rs2 = uses_rs2;  id_alu_ctrl = ctrl;
      id_reg_write = rw;  id_mem_read = mr;  id_mem_write = mw;
   endtask

   task automatic no_fwd();
      exm_reg_write = 1'b0;  exm_rd = 5'd0;  exm_result = 32'h0;
      mwb_reg_write = 1'b0;  mwb_rd = 5'd0;  mwb_data = 32'h0;
   endtask

   task automatic present_lw_x6();
      present(1'b1, 5'd1, 5'd0, 5'd6, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0010,
              1'b1, 1'b1, 1'b0);
   endtask

   task automatic present_sub_x7();
      present(1'b1, 5'd6, 5'd1, 5'd7, 32'h999, 32'h3, 32'h0, 1'b0, 1'b1, 4'b0110,
              1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      no_fwd();
      present(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000,
              1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_ex_valid", 32'(ex_valid), 32'h0);
      check("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
      check("rst_ex_rd", 32'(ex_rd), 32'h0);
      check("rst_alu_ctrl", 32'(ALU_ctrl), 32'h0);
      check("rst_op1", op1, 32'h0);
      check("rst_stall_count", 32'(stall_count), 32'h0);

      // add x3,x1,x2 with x1=5, x2=7, then addi x4,x0,9
      present(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 4'b0000,
              1'b1, 1'b0, 1'b0);
      #1 check("add_stall", 32'(stall), 32'h0);
      tick();
      present(1'b1, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'd9, 1'b1, 1'b0, 4'b0000,
              1'b1, 1'b0, 1'b0);
      #1;
      check("add_op1", op1, 32'd5);
      check("add_op2", op2, 32'd7);
      check("add_alu_ctrl", 32'(ALU_ctrl), 32'h0);
      check("add_ex_rd", 32'(ex_rd), 32'd3);
      check("add_ex_valid", 32'(ex_valid), 32'h1);
      check("addi_stall", 32'(stall), 32'h0);
      tick();
      check("addi_op1", op1, 32'h0);
      check("addi_op2", op2, 32'd9);
      check("addi_ex_rd", 32'(ex_rd), 32'd4);

      // Forwarding priority: rs1=x5 (stored 0x33), rs2=x6 (stored 0x44)
      present(1'b1, 5'd5, 5'd6, 5'd9, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 4'b0010,
              1'b1, 1'b0, 1'b0);
      tick();
      id_valid = 1'b0;
      exm_reg_write = 1'b1;  exm_rd = 5'd5;  exm_result = 32'h11;
      mwb_reg_write = 1'b1;  mwb_rd = 5'd5;  mwb_data = 32'h22;
      #1;
      check("fwd_exm_prio", op1, 32'h11);
      check("fwd_rs2_none", op2, 32'h44);
      check("fwd_alu_ctrl", 32'(ALU_ctrl), 32'h2);
      exm_reg_write = 1'b0;
      #1 check("fwd_mwb", op1, 32'h22);
      mwb_rd = 5'd6;
      #1;
      check("fwd_rs1_stored", op1, 32'h33);
      check("fwd_rs2_mwb", op2, 32'h22);
      check("fwd_store_mwb", ex_store_data, 32'h22);
      exm_reg_write = 1'b1;  exm_rd = 5'd6;
      #1 check("fwd_rs2_exm_prio", op2, 32'h11);
      no_fwd();

      // x0 never forwards
      present(1'b1, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h55, 1'b1, 1'b0, 4'b0000,
              1'b1, 1'b0, 1'b0);
      tick();
      id_valid = 1'b0;
      exm_reg_write = 1'b1;  exm_rd = 5'd0;  exm_result = 32'hFF;
      mwb_reg_write = 1'b1;  mwb_rd = 5'd0;  mwb_data = 32'hEE;
      #1;
      check("x0_op1", op1, 32'h0);
      check("x0_op2_imm", op2, 32'h55);
      check("x0_store", ex_store_data, 32'h0);
      no_fwd();

      // sw: op2 is the immediate, store data is forwarded rs2
      present(1'b1, 5'd2, 5'd8, 5'd0, 32'h100, 32'hAB, 32'h4, 1'b1, 1'b1, 4'b0000,
              1'b0, 1'b0, 1'b1);
      tick();
      id_valid = 1'b0;
      mwb_reg_write = 1'b1;  mwb_rd = 5'd8;  mwb_data = 32'hCD;
      #1;
      check("sw_op2", op2, 32'h4);
      check("sw_store_data", ex_store_data, 32'hCD);
      check("sw_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'h1);
      no_fwd();

      // Load-use: lw x6 in EX, sub x7,x6,x1 in decode
      present_lw_x6();
      #1 check("lw_stall", 32'(stall), 32'h0);
      tick();
      present_sub_x7();
      #1;
      check("lu_ex_mem_read", 32'(ex_mem_read), 32'h1);
      check("lu_stall", 32'(stall), 32'h1);
      tick();
      #1;
      check("lu_bubble_valid", 32'(ex_valid), 32'h0);
      check("lu_bubble_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
      check("lu_count", 32'(stall_count), 32'h1);
      check("lu_stall_clear", 32'(stall), 32'h0);
      tick();
      id_valid = 1'b0;
      mwb_reg_write = 1'b1;  mwb_rd = 5'd6;  mwb_data = 32'h77;
      #1;
      check("lu_sub_valid", 32'(ex_valid), 32'h1);
      check("lu_sub_rd", 32'(ex_rd), 32'd7);
      check("lu_sub_op1", op1, 32'h77);
      check("lu_sub_op2", op2, 32'h3);
      check("lu_sub_alu_ctrl", 32'(ALU_ctrl), 32'h6);
      no_fwd();

      // Flush during hazard: flush wins, no stall counted
      present_lw_x6();
      tick();
      present_sub_x7();
      flush = 1'b1;
      #1 check("fl_stall", 32'(stall), 32'h0);
      tick();
      flush = 1'b0;
      id_valid = 1'b0;
      #1;
      check("fl_ex_valid", 32'(ex_valid), 32'h0);
      check("fl_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
      check("fl_count", 32'(stall_count), 32'h1);

      // 20 more stalls: wide counter reaches 21, narrow counter pins at 0xF
      for (int i = 0; i < 20; i++) begin
         present_lw_x6();
         tick();
         present_sub_x7();
         tick();
      end
      id_valid = 1'b0;
      #1;
      check("sat_wide_count", 32'(stall_count), 32'd21);
      check("sat_narrow_count", 32'(s_stall_count), 32'hF);

      // Reset during a stall
      present_lw_x6();
      tick();
      present_sub_x7();
      #1 check("rst_pre_stall", 32'(stall), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      id_valid = 1'b0;
      #1;
      check("rst2_ex_valid", 32'(ex_valid), 32'h0);
      check("rst2_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
      check("rst2_ex_rd", 32'(ex_rd), 32'h0);
      check("rst2_alu_ctrl", 32'(ALU_ctrl), 32'h0);
      check("rst2_count", 32'(stall_count), 32'h0);
      check("rst2_narrow_count", 32'(s_stall_count), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
